if_prefetch: RTL and testbench
==============================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter INST_L, default 32, instruction width in bits (multiple of 8).
REQ-002 Parameter PC_L, default 32, program counter width.
REQ-003 Parameter MADDR_L, default 32, memory address width (<= PC_L).
REQ-004 Parameter DEPTH, default 4, prefetch queue entries (power of 2, >= 2).
REQ-005 Parameter RESET_PC, default 0, fetch address after reset.
REQ-006 The interface SHALL be one clock `clk`; reset `rst` is asynchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 jp_e  in  1  redirect request, one-cycle pulse.
REQ-010 pc_in  in  PC_L  redirect target.
REQ-011 re  out  1  memory read request.
REQ-012 addr  out  MADDR_L  read address, low MADDR_L bits of fetch PC.
REQ-013 r_len  out  2  read length code; constant 3 (4 bytes) while re=1, else 0.
REQ-014 mem_rdy  in  1  memory accepts request this cycle.
REQ-015 mem_rvalid  in  1  read data valid.
REQ-016 datain  in  INST_L  read data.
REQ-017 down_syn  out  1  instruction valid to decode.
REQ-018 down_ack  in  1  decode consumes instruction.
REQ-019 inst  out  INST_L  instruction at queue head.
REQ-020 inst_pc  out  PC_L  PC of inst.

Function
REQ-021 Handshakes SHALL be level valid/ready, sampled on clk rising edge: request accepted when re&mem_rdy; output transfer when down_syn&down_ack.
REQ-022 FSM states SHALL be IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-023 IDLE->REQ when count+0 < DEPTH; REQ holds re=1, addr stable until mem_rdy; REQ->WAIT on acceptance, fetch PC advances by 4 modulo 2^PC_L (wraps silently).
REQ-024 WAIT: on mem_rvalid write {PC, inst} into queue; next state REQ if space remains after write, else IDLE.
REQ-025 A request SHALL only be issued when occupied entries plus outstanding requests < DEPTH; queue never overflows.
REQ-026 Simultaneous pop and mem_rvalid with full-minus-one queue SHALL both complete in the same cycle.
REQ-027 Latency: datain valid at cycle t appears on inst with down_syn=1 at t+1 when queue was empty; first re at first clk edge after reset release.
REQ-028 jp_e=1: queue flushed, fetch PC <= pc_in, down_syn=0 next cycle; from REQ-before-accept or IDLE go to REQ; from WAIT (response pending, not arriving this cycle) go to DROP.
REQ-029 jp_e coincident with mem_rvalid: response discarded, go to REQ at pc_in.
REQ-030 jp_e coincident with a pop: flush wins; popped instruction counts as consumed.
REQ-031 DROP: discard next mem_rvalid data, then go to REQ; a further jp_e in DROP only updates fetch PC.
REQ-032 mem_rvalid in IDLE or REQ SHALL be ignored.
REQ-033 Zero-valued instructions SHALL be enqueued and delivered like any other.

Reset
REQ-034 On rst: state IDLE, fetch PC=RESET_PC, queue empty, re=0, addr=0, r_len=0, down_syn=0, inst=0, inst_pc=0; reset mid-transaction abandons any outstanding request.

Configuration
REQ-035 Macro IF_BSWAP_EN defined: stored inst is datain with byte order reversed (byte 0 to top byte); undefined: datain stored unchanged.

Structure
REQ-036 Shared package if_pkg SHALL hold the FSM state enum and the r_len word-length constant.
REQ-037 Queue SHALL be a sub-module if_fifo (DEPTH x (PC_L+INST_L), flush, count output).

Verification
REQ-038 Reset release, mem_rdy=1, rvalid one cycle after accept, down_ack=1 -> addr sequence 0,4,8,C; inst_pc matches; inst=datain (byte-swapped with IF_BSWAP_EN: 0x11223344 -> 0x44332211).
REQ-039 down_ack=0, DEPTH=4 -> exactly 4 requests issued, re stays 0, then one down_ack pulse -> one new request at 0x10.
REQ-040 jp_e with pc_in=0x100 while WAIT, stale rvalid 0xDEADBEEF -> 0xDEADBEEF never delivered; next inst_pc=0x100.
REQ-041 jp_e coincident with mem_rvalid and pop -> down_syn=0 next cycle, next re addr=pc_in.
REQ-042 Fetch PC 0xFFFFFFFC accepted -> next addr 0x00000000.
REQ-043 rst asserted in WAIT -> all outputs reset values immediately; late rvalid ignored; re restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types for the instruction prefetcher: fetch FSM states and the
// read-length code used for every memory request.
package if_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DROP = 2'd3
   } if_state_e;

   // Memory length code for a 4-byte word read.
   localparam logic [1:0] RLEN_WORD = 2'd3;

endpackage

// File: rtl/if_fifo.sv
// Prefetch queue: DEPTH entries of {pc, inst}, synchronous flush, occupancy count.
module if_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i)  rd_q <= rd_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage is not reset; the top masks the head while the queue is empty.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: one outstanding word read at a time into a small queue.
// Optional byte reversal of fetched words when IF_BSWAP_EN is defined.
//
//   state | meaning
//   IDLE  | queue has no room for another fetch
//   REQ   | re asserted, addr held until mem_rdy
//   WAIT  | request accepted, waiting for mem_rvalid
//   DROP  | redirected while a response is pending; discard it
module if_prefetch
   import if_pkg::*;
#(
   parameter int               INST_L   = 32,
   parameter int               PC_L     = 32,
   parameter int               MADDR_L  = 32,
   parameter int               DEPTH    = 4,
   parameter logic [PC_L-1:0]  RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               jp_e,
   input  logic [PC_L-1:0]    pc_in,
   output logic               re,
   output logic [MADDR_L-1:0] addr,
   output logic [1:0]         r_len,
   input  logic               mem_rdy,
   input  logic               mem_rvalid,
   input  logic [INST_L-1:0]  datain,
   output logic               down_syn,
   input  logic               down_ack,
   output logic [INST_L-1:0]  inst,
   output logic [PC_L-1:0]    inst_pc
);

   localparam int            CW       = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

   if_state_e                state_q, state_d;
   logic [PC_L-1:0]          pc_q, pc_d;
   logic [PC_L-1:0]          req_pc_q, req_pc_d;
   logic [CW-1:0]            count;
   logic                     push, pop;
   logic [INST_L-1:0]        inst_w;
   logic [PC_L+INST_L-1:0]   head;

`ifdef IF_BSWAP_EN
   always_comb begin
      inst_w = '0;
      for (int b = 0; b < INST_L / 8; b++) begin
         inst_w[8*b +: 8] = datain[INST_L-8-8*b +: 8];
      end
   end
`else
   assign inst_w = datain;
`endif

   assign down_syn = (count != '0);
   assign pop      = down_syn & down_ack;
   assign re       = (state_q == ST_REQ);
   assign addr     = re ? pc_q[MADDR_L-1:0] : '0;
   assign r_len    = re ? RLEN_WORD : 2'd0;
   assign inst     = down_syn ? head[INST_L-1:0] : '0;
   assign inst_pc  = down_syn ? head[PC_L+INST_L-1:INST_L] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      push     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (jp_e) begin
               pc_d    = pc_in;
               state_d = ST_REQ;
            end else if (count < DEPTH_C) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_rdy) req_pc_d = pc_q;
            // A redirect in the accepting cycle still leaves a response in flight.
            if (jp_e) begin
               pc_d    = pc_in;
               state_d = mem_rdy ? ST_DROP : ST_REQ;
            end else if (mem_rdy) begin
               pc_d    = pc_q + PC_L'(4);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (jp_e) begin
               pc_d    = pc_in;
               state_d = mem_rvalid ? ST_REQ : ST_DROP;
            end else if (mem_rvalid) begin
               push    = 1'b1;
               state_d = (!pop && count == DEPTH_M1) ? ST_IDLE : ST_REQ;
            end
         end
         ST_DROP: begin
            if (jp_e)       pc_d    = pc_in;
            if (mem_rvalid) state_d = ST_REQ;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   if_fifo #(
      .DEPTH (DEPTH),
      .W     (PC_L + INST_L)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (jp_e),
      .push_i  (push),
      .wdata_i ({req_pc_q, inst_w}),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (count)
   );

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: cycle vector table for startup and redirects, then a
// memory responder with an expected-instruction queue for longer sequences.
module tb_if_prefetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        jp_e;
   logic [31:0] pc_in;
   logic        re;
   logic [31:0] addr;
   logic [1:0]  r_len;
   logic        mem_rdy;
   logic        mem_rvalid;
   logic [31:0] datain;
   logic        down_syn;
   logic        down_ack;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   always #5 clk = ~clk;

   if_prefetch #(
      .INST_L (32), .PC_L (32), .MADDR_L (32), .DEPTH (4), .RESET_PC (32'h0)
   ) dut (
      .clk (clk), .rst (rst), .jp_e (jp_e), .pc_in (pc_in),
      .re (re), .addr (addr), .r_len (r_len),
      .mem_rdy (mem_rdy), .mem_rvalid (mem_rvalid), .datain (datain),
      .down_syn (down_syn), .down_ack (down_ack),
      .inst (inst), .inst_pc (inst_pc)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [31:0] xf(input logic [31:0] d);
`ifdef IF_BSWAP_EN
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
      return d;
`endif
   endfunction

   function automatic logic [31:0] mkdata(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   typedef struct {
      bit rdy; bit rv; logic [31:0] d; bit ack; bit jp; logic [31:0] pc;
      bit e_re; logic [31:0] e_addr; bit e_syn; logic [31:0] e_ipc; logic [31:0] e_inst;
   } vec_t;

   function automatic vec_t mkv(bit rdy, bit rv, logic [31:0] d, bit ack, bit jp,
                                logic [31:0] pc, bit e_re, logic [31:0] e_addr,
                                bit e_syn, logic [31:0] e_ipc, logic [31:0] e_inst);
      vec_t r;
      r.rdy = rdy; r.rv = rv; r.d = d; r.ack = ack; r.jp = jp; r.pc = pc;
      r.e_re = e_re; r.e_addr = e_addr; r.e_syn = e_syn; r.e_ipc = e_ipc; r.e_inst = e_inst;
      return r;
   endfunction

   // Responder / expected-queue state.
   logic [63:0] exp_q[$];
   bit          outst, drop, force_dead, cap_first, saw_wrap, found;
   int          wcnt, lat, n_acc;
   logic [31:0] out_addr, mdl_pc, last_acc, first_pc;
   bit          saw_dead = 1'b0;

   always @(negedge clk) begin
      if (!rst && down_syn && inst == xf(32'hDEADBEEF)) saw_dead = 1'b1;
   end

   task automatic mdl_clear();
      exp_q.delete();
      outst = 0; drop = 0; force_dead = 0; wcnt = 0;
      mdl_pc = 32'h0; last_acc = 32'h0;
   endtask

   task automatic cyc(input bit jp, input logic [31:0] pcin, input bit ack, input bit rdy);
      logic [31:0] d;
      logic [63:0] e;
      bit          rv;
      rv = outst && (wcnt == 0);
      d  = force_dead ? 32'hDEADBEEF : mkdata(out_addr);
      jp_e = jp; pc_in = pcin; down_ack = ack; mem_rdy = rdy;
      mem_rvalid = rv; datain = rv ? d : 32'h0;
      #1;
      if (down_syn && ack) begin
         chk("pop_expected", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pop_pc_inst", {inst_pc, inst}, e);
         end
         if (cap_first) begin
            first_pc  = inst_pc;
            cap_first = 0;
         end
      end
      if (rv) begin
         outst = 0;
         if (!jp && !drop) exp_q.push_back({out_addr, xf(d)});
         drop = 0; force_dead = 0;
      end else if (outst) begin
         wcnt--;
      end
      if (re && rdy) begin
         chk("acc_addr", 64'(addr), 64'(mdl_pc));
         if (mdl_pc == 32'h0 && last_acc == 32'hFFFFFFFC) saw_wrap = 1;
         last_acc = mdl_pc;
         n_acc++;
         outst = 1; wcnt = lat - 1; out_addr = mdl_pc;
         mdl_pc = mdl_pc + 32'd4;
      end
      if (jp) begin
         exp_q.delete();
         mdl_pc = pcin;
         if (outst && !rv) drop = 1;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1; jp_e = 0; pc_in = 0; mem_rdy = 0; mem_rvalid = 0; datain = 0; down_ack = 0;
      mdl_clear();
      @(posedge clk); #1;
      rst = 0;
   endtask

   vec_t tv[18];

   initial begin
      tv[0]  = mkv(1, 0, 32'h0,        1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0);
      tv[1]  = mkv(1, 0, 32'h0,        1, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0);
      tv[2]  = mkv(1, 1, 32'h11223344, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0);
      tv[3]  = mkv(1, 0, 32'h0,        1, 0, 32'h0,   1, 32'h4,   1, 32'h0,   32'h11223344);
      tv[4]  = mkv(1, 1, 32'h0,        1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0);
      tv[5]  = mkv(1, 0, 32'h0,        1, 0, 32'h0,   1, 32'h8,   1, 32'h4,   32'h0);
      tv[6]  = mkv(1, 1, 32'hA5A55A5A, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0);
      tv[7]  = mkv(1, 0, 32'h0,        1, 0, 32'h0,   1, 32'hC,   1, 32'h8,   32'hA5A55A5A);
      tv[8]  = mkv(1, 1, 32'h01020304, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0);
      tv[9]  = mkv(0, 0, 32'h0,        1, 0, 32'h0,   1, 32'h10,  1, 32'hC,   32'h01020304);
      tv[10] = mkv(0, 1, 32'hBAD0BAD0, 1, 0, 32'h0,   1, 32'h10,  0, 32'h0,   32'h0);
      tv[11] = mkv(0, 0, 32'h0,        1, 1, 32'h200, 1, 32'h10,  0, 32'h0,   32'h0);
      tv[12] = mkv(1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h200, 0, 32'h0,   32'h0);
      tv[13] = mkv(0, 1, 32'h55,       0, 1, 32'h300, 0, 32'h0,   0, 32'h0,   32'h0);
      tv[14] = mkv(0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h300, 0, 32'h0,   32'h0);
      tv[15] = mkv(1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h300, 0, 32'h0,   32'h0);
      tv[16] = mkv(0, 1, 32'h66,       0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0);
      tv[17] = mkv(0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h304, 1, 32'h300, 32'h66);

      rst = 1; jp_e = 0; pc_in = 0; mem_rdy = 0; mem_rvalid = 0; datain = 0; down_ack = 0;
      lat = 1; n_acc = 0; saw_wrap = 0; cap_first = 0; first_pc = 32'hFFFFFFFF;
      mdl_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_re",      64'(re),       64'(0));
      chk("rst_addr",    64'(addr),     64'(0));
      chk("rst_rlen",    64'(r_len),    64'(0));
      chk("rst_syn",     64'(down_syn), 64'(0));
      chk("rst_inst",    64'(inst),     64'(0));
      chk("rst_inst_pc", 64'(inst_pc),  64'(0));
      rst = 0;

      for (int k = 0; k < 18; k++) begin
         mem_rdy = tv[k].rdy; mem_rvalid = tv[k].rv; datain = tv[k].d;
         down_ack = tv[k].ack; jp_e = tv[k].jp; pc_in = tv[k].pc;
         #1;
         chk($sformatf("tv%0d_re", k),   64'(re),       64'(tv[k].e_re));
         chk($sformatf("tv%0d_rlen", k), 64'(r_len),    64'(tv[k].e_re ? 2'd3 : 2'd0));
         chk($sformatf("tv%0d_syn", k),  64'(down_syn), 64'(tv[k].e_syn));
         if (tv[k].e_re) chk($sformatf("tv%0d_addr", k), 64'(addr), 64'(tv[k].e_addr));
         if (tv[k].e_syn) begin
            chk($sformatf("tv%0d_ipc", k),  64'(inst_pc), 64'(tv[k].e_ipc));
            chk($sformatf("tv%0d_inst", k), 64'(inst),    64'(xf(tv[k].e_inst)));
         end
         @(posedge clk); #1;
      end

      // Back-pressure: queue fills to DEPTH, then one pop frees one fetch at 0x10.
      do_reset();
      lat = 1; n_acc = 0;
      repeat (20) cyc(0, 32'h0, 0, 1);
      chk("bp_acc4", 64'(n_acc),    64'(4));
      chk("bp_re0",  64'(re),       64'(0));
      chk("bp_syn",  64'(down_syn), 64'(1));
      cyc(0, 32'h0, 1, 1);
      repeat (6) cyc(0, 32'h0, 0, 1);
      chk("bp_acc5",   64'(n_acc),    64'(5));
      chk("bp_addr10", 64'(last_acc), 64'(32'h10));
      repeat (15) cyc(0, 32'h0, 1, 1);

      // Redirect while waiting; stale response must be dropped.
      lat = 3; found = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(0, 32'h0, 1, 1);
         if (outst) begin found = 1; break; end
      end
      chk("wait_found", 64'(found), 64'(1));
      force_dead = 1;
      cyc(1, 32'h100, 1, 1);
      cap_first = 1;
      chk("jp_syn0",  64'(down_syn), 64'(0));
      chk("drop_re0", 64'(re),       64'(0));
      repeat (15) cyc(0, 32'h0, 1, 1);
      chk("jp_first_pc", 64'(first_pc), 64'(32'h100));

      // Second redirect while already dropping only moves the fetch PC.
      found = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(0, 32'h0, 1, 1);
         if (outst) begin found = 1; break; end
      end
      chk("wait_found2", 64'(found), 64'(1));
      cyc(1, 32'h180, 1, 1);
      cyc(1, 32'h1C0, 1, 1);
      cap_first = 1;
      repeat (15) cyc(0, 32'h0, 1, 1);
      chk("drop_jp_first_pc", 64'(first_pc), 64'(32'h1C0));

      // Redirect coinciding with a response and a pop.
      lat = 1; found = 0;
      for (int i = 0; i < 30; i++) begin
         if (outst && wcnt == 0 && down_syn) begin found = 1; break; end
         cyc(0, 32'h0, 0, 1);
      end
      chk("c41_found", 64'(found), 64'(1));
      cyc(1, 32'h240, 1, 1);
      chk("c41_syn0", 64'(down_syn), 64'(0));
      chk("c41_re",   64'(re),       64'(1));
      chk("c41_addr", 64'(addr),     64'(32'h240));
      repeat (10) cyc(0, 32'h0, 1, 1);

      // Full-minus-one: pop and response in the same cycle keep fetching.
      cyc(1, 32'h400, 0, 1);
      found = 0;
      for (int i = 0; i < 30; i++) begin
         if (outst && wcnt == 0 && exp_q.size() == 3) begin found = 1; break; end
         cyc(0, 32'h0, 0, 1);
      end
      chk("fm1_found", 64'(found), 64'(1));
      cyc(0, 32'h0, 1, 1);
      chk("fm1_re",   64'(re),       64'(1));
      chk("fm1_syn",  64'(down_syn), 64'(1));
      repeat (15) cyc(0, 32'h0, 1, 1);

      // PC wrap past the top of the address space.
      cyc(1, 32'hFFFFFFF8, 1, 1);
      repeat (12) cyc(0, 32'h0, 1, 1);
      chk("wrap_seen", 64'(saw_wrap), 64'(1));

      // Reset while a response is outstanding.
      lat = 3; found = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(0, 32'h0, 0, 1);
         if (outst && exp_q.size() > 0) begin found = 1; break; end
      end
      chk("e_found",   64'(found),    64'(1));
      chk("e_syn_pre", 64'(down_syn), 64'(1));
      #2 rst = 1;
      #1;
      chk("arst_re",      64'(re),       64'(0));
      chk("arst_addr",    64'(addr),     64'(0));
      chk("arst_rlen",    64'(r_len),    64'(0));
      chk("arst_syn",     64'(down_syn), 64'(0));
      chk("arst_inst",    64'(inst),     64'(0));
      chk("arst_inst_pc", 64'(inst_pc),  64'(0));
      mdl_clear();
      jp_e = 0; mem_rdy = 0; down_ack = 1; mem_rvalid = 1; datain = 32'hDEADBEEF;
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      chk("rst2_re",   64'(re),       64'(1));
      chk("rst2_addr", 64'(addr),     64'(0));
      chk("rst2_syn",  64'(down_syn), 64'(0));
      @(posedge clk); #1;
      chk("rst2_syn_b", 64'(down_syn), 64'(0));
      mem_rvalid = 0;
      repeat (12) cyc(0, 32'h0, 1, 1);

      chk("no_stale_dead", 64'(saw_dead), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
